spart_fifo: RTL

Parametrised, buffered successor to the single-register SPART bus interface. It sits between the processor bus (`iocs`/`iorw`/`ioaddr`/`databus`) and the existing `spart_tx`/`spart_rx` serial engines. It adds a TX FIFO and an RX FIFO of configurable depth and a configurable data width. It also adds a level-based status register with sticky overrun, plus a TX launch state machine that streams queued words to the transmitter without processor intervention.

---
 rtl/spart_fifo_if.sv | 25 ++
 rtl/spart_fifo.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/spart_fifo_if.sv
// spart_fifo_if: processor bus control plus the serial-engine handshake of spart_fifo.
// The bidirectional databus stays a plain inout port on the block itself.
interface spart_fifo_if #(
  parameter int DATA_W = 8
);
  logic              iocs;
  logic              iorw;
  logic [1:0]        ioaddr;
  logic [15:0]       divisor_buffer;
  logic [DATA_W-1:0] transmit_buffer;
  logic              tx_begin;
  logic              tx_tbr;
  logic              rx_done;
  logic [DATA_W+1:0] rx_shift_reg;

  modport master (
    output iocs, iorw, ioaddr, tx_tbr, rx_done, rx_shift_reg,
    input  divisor_buffer, transmit_buffer, tx_begin
  );

  modport slave (
    input  iocs, iorw, ioaddr, tx_tbr, rx_done, rx_shift_reg,
    output divisor_buffer, transmit_buffer, tx_begin
  );
endinterface

// File: rtl/spart_fifo.sv
// spart_fifo: buffered SPART bus interface with TX/RX FIFOs, sticky overrun and a TX launch FSM.
// Optional feature macro: SPART_RX_IRQ_EN (registered level/overrun interrupt; irq tied low otherwise).
module spart_fifo #(
  parameter int DATA_W    = 8,
  parameter int TX_DEPTH  = 4,
  parameter int RX_DEPTH  = 4,
  parameter int RX_THRESH = 1
) (
  input  logic       clk,
  input  logic       rst,
  spart_fifo_if.slave bus,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       irq
);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int TX_LW = TX_AW + 1;
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int RX_LW = RX_AW + 1;

  if (DATA_W < 1 || DATA_W > 8 || TX_DEPTH < 2 || RX_DEPTH < 2 ||
      (TX_DEPTH & (TX_DEPTH - 1)) != 0 || (RX_DEPTH & (RX_DEPTH - 1)) != 0 ||
      RX_THRESH < 1 || RX_THRESH > RX_DEPTH) begin : g_bad_params
    $error("spart_fifo: illegal parameter set");
  end

  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_LAUNCH    = 2'd1,
    TX_WAIT_BUSY = 2'd2,
    TX_WAIT_DONE = 2'd3
  } tx_state_t;

  logic [DATA_W-1:0] r_tx_mem [TX_DEPTH];
  logic [TX_AW-1:0]  r_tx_wptr;
  logic [TX_AW-1:0]  r_tx_rptr;
  logic [TX_LW-1:0]  r_tx_level;
  logic [DATA_W-1:0] r_rx_mem [RX_DEPTH];
  logic [RX_AW-1:0]  r_rx_wptr;
  logic [RX_AW-1:0]  r_rx_rptr;
  logic [RX_LW-1:0]  r_rx_level;
  tx_state_t         r_tx_state;
  tx_state_t         w_tx_next;
  logic [DATA_W-1:0] r_tx_buf;
  logic              r_tx_begin;
  logic              r_overrun;
  logic [7:0]        r_db_low;
  logic [7:0]        r_db_high;

  logic              w_cpu_rd;
  logic              w_cpu_wr;
  logic              w_tx_empty;
  logic              w_tx_full;
  logic              w_tx_push;
  logic              w_tx_pop;
  logic              w_rx_empty;
  logic              w_rx_full;
  logic              w_rx_push;
  logic              w_rx_pop;
  logic              w_ovr_set;
  logic              w_stat_rd;
  logic              w_tx_idle;
  logic [7:0]        w_rdata;
  logic [DATA_W-1:0] w_wdata;
  logic              w_unused_frame_bits;

  assign w_cpu_rd   = bus.iocs && bus.iorw;
  assign w_cpu_wr   = bus.iocs && !bus.iorw;
  assign w_wdata    = databus[DATA_W-1:0];
  assign w_tx_empty = (r_tx_level == {TX_LW{1'b0}});
  assign w_tx_full  = (r_tx_level == TX_LW'(TX_DEPTH));
  assign w_rx_empty = (r_rx_level == {RX_LW{1'b0}});
  assign w_rx_full  = (r_rx_level == RX_LW'(RX_DEPTH));

  // A push on a full FIFO is accepted only when a pop frees the slot on the same edge.
  assign w_tx_push  = w_cpu_wr && (bus.ioaddr == 2'b00) && (!w_tx_full || w_tx_pop);
  assign w_rx_pop   = w_cpu_rd && (bus.ioaddr == 2'b00) && !w_rx_empty;
  assign w_rx_push  = bus.rx_done && (!w_rx_full || w_rx_pop);
  assign w_ovr_set  = bus.rx_done && w_rx_full && !w_rx_pop;
  assign w_stat_rd  = w_cpu_rd && (bus.ioaddr == 2'b01);
  assign w_tx_idle  = w_tx_empty && (r_tx_state == TX_IDLE) && bus.tx_tbr;

  assign rda                 = !w_rx_empty;
  assign tbr                 = !w_tx_full;
  assign bus.divisor_buffer  = {r_db_high, r_db_low};
  assign bus.transmit_buffer = r_tx_buf;
  assign bus.tx_begin        = r_tx_begin;
  assign databus             = w_cpu_rd ? w_rdata : 8'bzzzz_zzzz;
  assign w_unused_frame_bits = bus.rx_shift_reg[0] ^ bus.rx_shift_reg[DATA_W+1];

  // TX launch next-state and FIFO pop decode
  always_comb begin
    w_tx_next = r_tx_state;
    w_tx_pop  = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        if (!w_tx_empty && bus.tx_tbr) begin
          w_tx_pop  = 1'b1;
          w_tx_next = TX_LAUNCH;
        end else begin
          w_tx_next = TX_IDLE;
        end
      end
      TX_LAUNCH:    w_tx_next = TX_WAIT_BUSY;
      TX_WAIT_BUSY: begin
        if (!bus.tx_tbr) w_tx_next = TX_WAIT_DONE;
        else             w_tx_next = TX_WAIT_BUSY;
      end
      TX_WAIT_DONE: begin
        if (bus.tx_tbr) w_tx_next = TX_IDLE;
        else            w_tx_next = TX_WAIT_DONE;
      end
      default: w_tx_next = TX_IDLE;
    endcase
  end

  // TX state register, launch pulse and transmit word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_begin <= 1'b0;
      r_tx_buf   <= {DATA_W{1'b0}};
    end else begin
      r_tx_state <= w_tx_next;
      r_tx_begin <= (w_tx_next == TX_LAUNCH);
      if (w_tx_pop) r_tx_buf <= r_tx_mem[r_tx_rptr];
    end
  end

  // TX FIFO storage, pointers and level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TX_DEPTH; i++) r_tx_mem[i] <= {DATA_W{1'b0}};
      r_tx_wptr  <= {TX_AW{1'b0}};
      r_tx_rptr  <= {TX_AW{1'b0}};
      r_tx_level <= {TX_LW{1'b0}};
    end else begin
      if (w_tx_push) begin
        r_tx_mem[r_tx_wptr] <= w_wdata;
        r_tx_wptr           <= r_tx_wptr + TX_AW'(1);
      end
      if (w_tx_pop) r_tx_rptr <= r_tx_rptr + TX_AW'(1);
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_level <= r_tx_level + TX_LW'(1);
        2'b01:   r_tx_level <= r_tx_level - TX_LW'(1);
        default: r_tx_level <= r_tx_level;
      endcase
    end
  end

  // RX FIFO storage, pointers and level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RX_DEPTH; i++) r_rx_mem[i] <= {DATA_W{1'b0}};
      r_rx_wptr  <= {RX_AW{1'b0}};
      r_rx_rptr  <= {RX_AW{1'b0}};
      r_rx_level <= {RX_LW{1'b0}};
    end else begin
      if (w_rx_push) begin
        r_rx_mem[r_rx_wptr] <= bus.rx_shift_reg[DATA_W:1];
        r_rx_wptr           <= r_rx_wptr + RX_AW'(1);
      end
      if (w_rx_pop) r_rx_rptr <= r_rx_rptr + RX_AW'(1);
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_level <= r_rx_level + RX_LW'(1);
        2'b01:   r_rx_level <= r_rx_level - RX_LW'(1);
        default: r_rx_level <= r_rx_level;
      endcase
    end
  end

  // Sticky overrun; a fresh overrun beats the clear from a status read
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_overrun <= 1'b0;
    else if (w_ovr_set) r_overrun <= 1'b1;
    else if (w_stat_rd) r_overrun <= 1'b0;
    else                r_overrun <= r_overrun;
  end

  // Baud divisor bytes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_db_low  <= 8'h00;
      r_db_high <= 8'h00;
    end else if (w_cpu_wr && (bus.ioaddr == 2'b10)) begin
      r_db_low  <= databus;
    end else if (w_cpu_wr && (bus.ioaddr == 2'b11)) begin
      r_db_high <= databus;
    end else begin
      r_db_low  <= r_db_low;
      r_db_high <= r_db_high;
    end
  end

  // Read data mux, combinational from current head/status
  always_comb begin
    w_rdata = 8'h00;
    case (bus.ioaddr)
      2'b00: begin
        if (!w_rx_empty) w_rdata = 8'(r_rx_mem[r_rx_rptr]);
        else             w_rdata = 8'h00;
      end
      2'b01:   w_rdata = {4'b0000, w_tx_idle, r_overrun, tbr, rda};
      2'b10:   w_rdata = r_db_low;
      2'b11:   w_rdata = r_db_high;
      default: w_rdata = 8'h00;
    endcase
  end

`ifdef SPART_RX_IRQ_EN
  logic r_irq;

  // Interrupt from RX level threshold or overrun, one cycle behind the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_irq <= 1'b0;
    else     r_irq <= (r_rx_level >= RX_LW'(RX_THRESH)) || r_overrun;
  end

  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

endmodule
